// File: rtl/dtmr_fault_mgr_pkg.sv
// Shared definitions for the Dynamic TMR fault manager: FSM encoding,
// copy bit positions within fault/mod_rst/failed, and counter widths.
package dtmr_fault_mgr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_VOTE    = 2'd2,
        ST_RECOVER = 2'd3
    } fsm_state_e;

    localparam int COPY1   = 2;
    localparam int COPY2   = 1;
    localparam int COPY3   = 0;
    localparam int RECOV_W = 8;
    localparam int RETRY_W = 2;

    // copy1 wins over copy2, which wins over copy3
    function automatic logic [2:0] prio_onehot(input logic [2:0] v);
        logic [2:0] sel;
        sel = 3'b000;
        if (v[COPY1])      sel[COPY1] = 1'b1;
        else if (v[COPY2]) sel[COPY2] = 1'b1;
        else if (v[COPY3]) sel[COPY3] = 1'b1;
        return sel;
    endfunction

    function automatic logic two_or_more(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/dtmr_fault_mgr_retry_ctr.sv
// Per-copy recovery counter; saturates at MAX_RETRY and flags it with hit.
module dtmr_retry_ctr
    import dtmr_fault_mgr_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [RETRY_W-1:0] cnt,
    output logic               hit
);

    logic [RETRY_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = (cnt_q == RETRY_W'(MAX_RETRY));

endmodule

// File: rtl/dtmr_fault_mgr.sv
// Dynamic TMR supervisor: switches the voter between simplex and voting,
// pulses resets to faulty copies and retires copies that keep failing.
module dtmr_fault_mgr
    import dtmr_fault_mgr_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int RST_CYCLES    = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic [2:0]         fault,
    output logic               state,
    output logic [2:0]         mod_rst,
    output logic [2:0]         failed,
    output logic               alarm,
    output logic [RECOV_W-1:0] recov_cnt
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int PULSE_W  = $clog2(RST_CYCLES + 1);

    fsm_state_e         fsm_q, fsm_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic [2:0]          tgt_q, tgt_d;
    logic                state_q, state_d;
    logic [2:0]          mod_rst_q, mod_rst_d;
    logic [2:0]          failed_q, failed_d;
    logic                alarm_q, alarm_d;
    logic [RECOV_W-1:0]  recov_q, recov_d;

    logic [2:0]          eff;
    logic [2:0]          retry_inc;
    logic [2:0]          retry_hit;
    logic                retry_clr;
    logic [RETRY_W-1:0]  retry_cnt [3];
    logic [RETRY_W-1:0]  tgt_cnt;

    assign eff = fault & ~failed_q;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_retry
            dtmr_retry_ctr #(.MAX_RETRY(MAX_RETRY)) u_retry (
                .clk (clk),
                .rst (rst),
                .inc (retry_inc[gi]),
                .clr (retry_clr),
                .cnt (retry_cnt[gi]),
                .hit (retry_hit[gi])
            );
        end
    endgenerate

    always_comb begin
        tgt_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            if (tgt_q[i]) tgt_cnt = retry_cnt[i];
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        settle_d  = settle_q;
        hold_d    = hold_q;
        pulse_d   = pulse_q;
        tgt_d     = tgt_q;
        mod_rst_d = mod_rst_q;
        recov_d   = recov_q;
        retry_inc = 3'b000;
        retry_clr = 1'b0;
        // retry count is bumped on entry to RECOVER, so hit marks the retirement
        failed_d  = failed_q | retry_hit;

        case (fsm_q)
            ST_IDLE: begin
                if (trigger || failed_q[COPY1]) begin
                    fsm_d    = ST_ARM;
                    settle_d = '0;
                end
            end
            ST_ARM: begin
                if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    fsm_d  = ST_VOTE;
                    hold_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_VOTE: begin
                if (eff != 3'b000) begin
                    fsm_d     = ST_RECOVER;
                    tgt_d     = prio_onehot(eff);
                    retry_inc = prio_onehot(eff);
                    pulse_d   = '0;
                end else if (trigger) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    // a retired copy1 or a raised alarm pins us in voting mode
                    if (!failed_q[COPY1] && !alarm_q) begin
                        fsm_d     = ST_IDLE;
                        hold_d    = '0;
                        retry_clr = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RECOVER: begin
                if (pulse_q == '0) begin
                    if (tgt_cnt == RETRY_W'(MAX_RETRY)) begin
                        fsm_d  = ST_VOTE;
                        hold_d = '0;
                    end else begin
                        mod_rst_d = tgt_q;
                        pulse_d   = PULSE_W'(1);
                        if (recov_q != '1) recov_d = recov_q + 1'b1;
                    end
                end else if (pulse_q == PULSE_W'(RST_CYCLES)) begin
                    mod_rst_d = 3'b000;
                    fsm_d     = ST_ARM;
                    settle_d  = '0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        state_d = (fsm_d != ST_IDLE);
        alarm_d = alarm_q | two_or_more(failed_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= ST_IDLE;
            settle_q  <= '0;
            hold_q    <= '0;
            pulse_q   <= '0;
            tgt_q     <= 3'b000;
            state_q   <= 1'b0;
            mod_rst_q <= 3'b000;
            failed_q  <= 3'b000;
            alarm_q   <= 1'b0;
            recov_q   <= '0;
        end else begin
            fsm_q     <= fsm_d;
            settle_q  <= settle_d;
            hold_q    <= hold_d;
            pulse_q   <= pulse_d;
            tgt_q     <= tgt_d;
            state_q   <= state_d;
            mod_rst_q <= mod_rst_d;
            failed_q  <= failed_d;
            alarm_q   <= alarm_d;
            recov_q   <= recov_d;
        end
    end

    assign state     = state_q;
    assign mod_rst   = mod_rst_q;
    assign failed    = failed_q;
    assign alarm     = alarm_q;
    assign recov_cnt = recov_q;

endmodule

// File: tb/tb_dtmr_fault_mgr.sv
// Directed bench for dtmr_fault_mgr: escalation, recovery pulses,
// retirement, alarm and asynchronous reset, with hand-computed expectations.
module tb_dtmr_fault_mgr;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic [2:0] fault;
    logic       state;
    logic [2:0] mod_rst;
    logic [2:0] failed;
    logic       alarm;
    logic [7:0] recov_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] bits_a, bits_b;
    int         width_a, width_b, n_high;

    always #5 clk = ~clk;

    dtmr_fault_mgr dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .fault     (fault),
        .state     (state),
        .mod_rst   (mod_rst),
        .failed    (failed),
        .alarm     (alarm),
        .recov_cnt (recov_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) begin
            $display("[TB] ok   %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        trigger = 1'b0;
        fault   = 3'b000;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // IDLE -> ARM (2 settle cycles) -> first VOTE cycle
    task automatic enter_vote();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
    endtask

    task automatic measure_pulse(output logic [2:0] bits, output int width);
        bits  = 3'b000;
        width = 0;
        for (int i = 0; i < 8 && mod_rst == 3'b000; i++) tick();
        bits = mod_rst;
        while (bits != 3'b000 && mod_rst == bits && width < 20) begin
            width++;
            tick();
        end
    endtask

    // one-cycle fault in VOTE that leads to a pulse, then back to VOTE
    task automatic recover(input logic [2:0] f, input logic [2:0] arm_f,
                           output logic [2:0] bits, output int width);
        fault = f;
        tick();
        fault = 3'b000;
        measure_pulse(bits, width);
        fault = arm_f;
        tick();
        tick();
        fault = 3'b000;
    endtask

    // one-cycle fault in VOTE that retires the copy, back in VOTE afterwards
    task automatic retire(input logic [2:0] f);
        fault = f;
        tick();
        fault = 3'b000;
        tick();
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (state == 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state and a clean escalation round trip
        do_reset();
        check("rst_state", state, 0);
        check("rst_mod_rst", mod_rst, 0);
        check("rst_failed", failed, 0);
        check("rst_alarm", alarm, 0);
        check("rst_recov", recov_cnt, 0);

        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        count_high(n_high);
        check("clean_state_high_cycles", n_high, 18);
        check("clean_state_back", state, 0);
        check("clean_mod_rst", mod_rst, 0);
        check("clean_recov", recov_cnt, 0);

        // trigger in VOTE restarts the hold window
        enter_vote();
        repeat (10) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        count_high(n_high);
        check("trig_hold_restart", n_high, 16);

        // single copy2 recovery, fault ignored during ARM settle
        do_reset();
        enter_vote();
        recover(3'b010, 3'b111, bits_a, width_a);
        check("c2_pulse_bits", bits_a, 3'b010);
        check("c2_pulse_width", width_a, 4);
        check("c2_recov", recov_cnt, 1);
        check("c2_after_arm_mod_rst", mod_rst, 0);
        repeat (3) tick();
        check("c2_arm_ignored_recov", recov_cnt, 1);
        check("c2_state_vote", state, 1);

        // copy3 retired after MAX_RETRY faults
        do_reset();
        enter_vote();
        recover(3'b001, 3'b000, bits_a, width_a);
        check("c3_p1_bits", bits_a, 3'b001);
        check("c3_p1_width", width_a, 4);
        recover(3'b001, 3'b000, bits_b, width_b);
        check("c3_p2_bits", bits_b, 3'b001);
        check("c3_p2_width", width_b, 4);
        retire(3'b001);
        check("c3_failed", failed, 3'b001);
        check("c3_no_pulse", mod_rst, 0);
        check("c3_recov", recov_cnt, 2);
        fault = 3'b001;
        count_high(n_high);
        fault = 3'b000;
        check("c3_hold_with_masked_fault", n_high, 16);
        check("c3_recov_after", recov_cnt, 2);
        check("c3_failed_sticky", failed, 3'b001);

        // simultaneous faults: copy1 first, copy2 after settle
        do_reset();
        enter_vote();
        fault = 3'b110;
        tick();
        fault = 3'b010;
        measure_pulse(bits_a, width_a);
        measure_pulse(bits_b, width_b);
        fault = 3'b000;
        check("multi_first_bits", bits_a, 3'b100);
        check("multi_first_width", width_a, 4);
        check("multi_second_bits", bits_b, 3'b010);
        check("multi_second_width", width_b, 4);
        check("multi_recov", recov_cnt, 2);

        // retire copy1 (voting forever), then copy3 raises the alarm
        do_reset();
        enter_vote();
        recover(3'b100, 3'b000, bits_a, width_a);
        check("c1_p1_bits", bits_a, 3'b100);
        recover(3'b100, 3'b000, bits_b, width_b);
        check("c1_p2_bits", bits_b, 3'b100);
        retire(3'b100);
        check("c1_failed", failed, 3'b100);
        check("c1_alarm_low", alarm, 0);
        repeat (100) tick();
        check("c1_state_stays", state, 1);
        recover(3'b001, 3'b000, bits_a, width_a);
        check("c1c3_p1_bits", bits_a, 3'b001);
        recover(3'b001, 3'b000, bits_b, width_b);
        check("c1c3_p2_width", width_b, 4);
        retire(3'b001);
        check("c1c3_failed", failed, 3'b101);
        check("c1c3_alarm", alarm, 1);
        check("c1c3_recov", recov_cnt, 4);
        repeat (40) tick();
        check("c1c3_state_stays", state, 1);

        // asynchronous reset in the middle of a pulse
        do_reset();
        enter_vote();
        fault = 3'b010;
        tick();
        fault = 3'b000;
        tick();
        check("arst_pulse_started", mod_rst, 3'b010);
        tick();
        rst = 1'b1;
        #1;
        check("arst_mod_rst", mod_rst, 0);
        check("arst_state", state, 0);
        check("arst_recov", recov_cnt, 0);
        check("arst_failed", failed, 0);
        check("arst_alarm", alarm, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_idle_after", state, 0);
        check("arst_mod_rst_after", mod_rst, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
